// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and helpers for the UART rx/tx pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Clocks per oversample tick; both the receiver and transmitter derive their rate from this.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module      : uart_baud_gen
// Description : Free-running oversample tick generator, one-cycle tick every DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 oversampling UART receiver with valid/read host handshake.
//               Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote at each sample point.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_100m,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int SCW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_DELAY = 1;
`else
  localparam int MAJ_DELAY = 0;
`endif
  localparam logic [SCW-1:0] START_THR = SCW'(OVERSAMPLE / 2 - 1 + MAJ_DELAY);
  localparam logic [SCW-1:0] BIT_THR   = SCW'(OVERSAMPLE - 1);
  localparam logic [2:0]     LAST_IDX  = 3'(DATA_BITS - 1);

  logic                 tick;
  logic                 samp;
  logic                 byte_done;
  logic                 rd_ok;

  logic                 rx_meta_q;
  logic                 rs_q;
  uart_state_e          state_q;
  logic [SCW-1:0]       sc_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q;
  logic                 rx_busy_q;

  logic [DATA_BITS-1:0] data_out_q,   data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 overrun_q,    overrun_d;

  uart_baud_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clk_i  (clk_100m),
    .rst_ni (rst_n),
    .tick_o (tick)
  );

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Two previous tick samples; together with rs_q they span centre-1..centre+1.
  logic [1:0] hist_q;

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else if (tick) begin
      hist_q <= {hist_q[0], rs_q};
    end
  end

  assign samp = maj3(hist_q[1], hist_q[0], rs_q);
`else
  assign samp = rs_q;
`endif

  assign byte_done = tick && (state_q == STOP) && (sc_q == BIT_THR) && samp;
  assign rd_ok     = rd_en && data_valid_q;

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sc_q        <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (!rs_q) begin
              state_q   <= START;
              sc_q      <= '0;
              rx_busy_q <= 1'b1;
            end
          end
          START: begin
            if (sc_q == START_THR) begin
              if (samp) begin
                state_q   <= IDLE;
                rx_busy_q <= 1'b0;
              end else begin
                state_q <= DATA;
                sc_q    <= '0;
                idx_q   <= '0;
              end
            end else begin
              sc_q <= sc_q + 1'b1;
            end
          end
          DATA: begin
            if (sc_q == BIT_THR) begin
              shift_q[idx_q] <= samp;
              sc_q           <= '0;
              if (idx_q == LAST_IDX) begin
                state_q <= STOP;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              sc_q <= sc_q + 1'b1;
            end
          end
          STOP: begin
            if (sc_q == BIT_THR) begin
              sc_q <= '0;
              if (samp) begin
                state_q   <= IDLE;
                rx_busy_q <= 1'b0;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= BRK;
              end
            end else begin
              sc_q <= sc_q + 1'b1;
            end
          end
          BRK: begin
            // A held-low line must return high before a new start edge can be seen.
            if (rs_q) begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // A completing byte always wins over a read; a concurrent read just suppresses overrun.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    if (byte_done) begin
      data_out_d   = shift_q;
      data_valid_d = 1'b1;
      overrun_d    = !rd_ok && (overrun_q || data_valid_q);
    end else if (rd_ok) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign rx_busy    = rx_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (4-clock tick, 64 clocks per bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CLK_FREQ   = 100_000_000;
  localparam int BAUD       = 1_562_500;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = 64;

  logic       clk_100m = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic       rd_en    = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int tests     = 0;
  int fails     = 0;
  int cyc       = 0;
  int ferr_cnt  = 0;
  int ferr_base = 0;
  int race_rise = -1;

  typedef struct {
    logic [7:0] data;
    logic       read_first;
    logic [7:0] exp_out;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk_100m   (clk_100m),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  always #5 clk_100m = ~clk_100m;

  always @(posedge clk_100m) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk_100m) begin
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk_100m);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    rd_en = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2);
  endtask

  task automatic rd_pulse();
    rd_en = 1'b1;
    wait_clks(1);
    rd_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic glitch_bit(input logic v);
    rx = v;
    wait_clks(BIT_CLKS / 2 - 2);
    rx = ~v;
    wait_clks(4);
    rx = v;
    wait_clks(BIT_CLKS / 2 - 2);
  endtask

  task automatic send_glitchy(input logic [7:0] b);
    glitch_bit(1'b0);
    for (int i = 0; i < 8; i++) glitch_bit(b[i]);
    glitch_bit(1'b1);
    rx = 1'b1;
  endtask
`endif

  // rd_cyc < 0: calibration run, records the cycle data_valid rises for 0x7E.
  // rd_cyc >= 0: leaves 0x11 unread and pulses rd_en exactly at that completion edge.
  task automatic seq_rd_race(input int rd_cyc);
    do_reset();
    send_byte(8'h11, 1'b1);
    rd_en = (rd_cyc < 0);
    wait_clks(1);
    rd_en = 1'b0;
    fork
      send_byte(8'h7E, 1'b1);
      begin
        for (int k = 0; k < 1000; k++) begin
          if (rd_cyc >= 0) rd_en = (cyc == rd_cyc - 1);
          if (rd_cyc < 0 && data_valid) begin
            race_rise = cyc;
            break;
          end
          if (rd_cyc >= 0 && cyc == rd_cyc) break;
          wait_clks(1);
        end
        rd_en = 1'b0;
      end
    join
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h55, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h12, 1'b1, 8'h12, 1'b1, 1'b0};
    vecs[5] = '{8'h34, 1'b0, 8'h34, 1'b1, 1'b1};

    wait_clks(3);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    wait_clks(5);

    for (int v = 0; v < 6; v++) begin
      ferr_base = ferr_cnt;
      if (vecs[v].read_first) rd_pulse();
      send_byte(vecs[v].data, 1'b1);
      check($sformatf("vec%0d_data_out", v), data_out, vecs[v].exp_out);
      check($sformatf("vec%0d_valid", v), data_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_overrun", v), overrun, vecs[v].exp_ovr);
      check($sformatf("vec%0d_busy", v), rx_busy, 1'b0);
      check($sformatf("vec%0d_frame_err", v), ferr_cnt - ferr_base, 0);
    end

    rd_pulse();
    check("read_clr_valid", data_valid, 1'b0);
    check("read_clr_overrun", overrun, 1'b0);
    check("read_keeps_data", data_out, 8'h34);

    ferr_base = ferr_cnt;
    rx = 1'b0;
    wait_clks(12);
    check("glitch_busy", rx_busy, 1'b1);
    rx = 1'b1;
    wait_clks(100);
    check("glitch_idle", rx_busy, 1'b0);
    check("glitch_valid", data_valid, 1'b0);
    check("glitch_frame_err", ferr_cnt - ferr_base, 0);
    check("glitch_data_out", data_out, 8'h34);

    ferr_base = ferr_cnt;
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = (8'hA3 >> i) & 8'h01;
      wait_clks(BIT_CLKS);
    end
    rx = 1'b0;
    wait_clks(2 * BIT_CLKS);
    check("brk_frame_err_pulse", ferr_cnt - ferr_base, 1);
    check("brk_valid", data_valid, 1'b0);
    check("brk_busy", rx_busy, 1'b1);
    rx = 1'b1;
    wait_clks(20);
    check("brk_released", rx_busy, 1'b0);
    send_byte(8'h0F, 1'b1);
    check("after_brk_data", data_out, 8'h0F);
    check("after_brk_valid", data_valid, 1'b1);
    check("after_brk_no_ferr", ferr_cnt - ferr_base, 1);

    race_rise = -1;
    seq_rd_race(-1);
    check("race_calibrated", (race_rise > 0), 1'b1);
    seq_rd_race((race_rise > 0) ? race_rise : 1);
    check("race_valid", data_valid, 1'b1);
    check("race_data_out", data_out, 8'h7E);
    check("race_overrun", overrun, 1'b0);

    ferr_base = ferr_cnt;
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(3 * BIT_CLKS);
    check("midframe_busy", rx_busy, 1'b1);
    rst_n = 1'b0;
    wait_clks(2);
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_valid", data_valid, 1'b0);
    check("midrst_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    wait_clks(10);
    send_byte(8'h81, 1'b1);
    check("post_rst_data", data_out, 8'h81);
    check("post_rst_valid", data_valid, 1'b1);
    check("post_rst_overrun", overrun, 1'b0);
    check("post_rst_ferr", ferr_cnt - ferr_base, 0);

`ifdef UART_RX_MAJORITY_EN
    rd_pulse();
    send_glitchy(8'h81);
    check("maj_data_81", data_out, 8'h81);
    check("maj_valid_81", data_valid, 1'b1);
    rd_pulse();
    send_glitchy(8'hC6);
    check("maj_data_c6", data_out, 8'hC6);
    check("maj_ferr", ferr_cnt - ferr_base, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
